// File: rtl/gerador_sincronismo.sv
// gerador_sincronismo: VGA timing generator (640x480@60 Hz by default), clocked by the
// 25 MHz pixel clock.
//
// Two free-running counters (hcount across a line, vcount across a frame) are decoded
// into the sync/active strobes, the visible pixel coordinates and a frame-start pulse.
// Every output is registered from the decode of the counters' *next* value, so in any
// cycle the outputs describe exactly the pixel the counters hold in that cycle.
//
// Ports:
//   clk25       in   pixel clock, rising edge
//   reset       in   synchronous, active-high reset
//   Hsync       out  horizontal sync, active-low
//   Hactive     out  high during visible columns
//   Vsync       out  vertical sync, active-low
//   Vactive     out  high during visible lines
//   enable      out  Hactive & Vactive
//   Row         out  visible line (0 outside Vactive)
//   Col         out  visible column (0 outside Hactive)
//   frame_start out  one-cycle pulse at pixel (0,0)
module gerador_sincronismo #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk25,
  input  logic       reset,
  output logic       Hsync,
  output logic       Hactive,
  output logic       Vsync,
  output logic       Vactive,
  output logic       enable,
  output logic [8:0] Row,
  output logic [9:0] Col,
  output logic       frame_start
);

  // Region boundaries as 10-bit constants; sync end is exclusive.
  localparam logic [9:0] HActive    = 10'(H_ACTIVE);
  localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HLast      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

  localparam logic [9:0] VActive    = 10'(V_ACTIVE);
  localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VLast      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       h_wrap, v_wrap;

  logic       hsync_d, hactive_d, vsync_d, vactive_d, enable_d, frame_start_d;
  logic [8:0] row_d;
  logic [9:0] col_d;

  always_comb begin
    h_wrap   = (hcount_q == HLast);
    v_wrap   = (vcount_q == VLast);
    hcount_d = h_wrap ? 10'd0 : hcount_q + 10'd1;
    vcount_d = vcount_q;
    // vcount only advances on the line wrap, so vertical outputs move only at hcount = 0.
    if (h_wrap) begin
      vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
    end

    hactive_d     = (hcount_d < HActive);
    hsync_d       = ~((hcount_d >= HSyncStart) && (hcount_d < HSyncEnd));
    vactive_d     = (vcount_d < VActive);
    vsync_d       = ~((vcount_d >= VSyncStart) && (vcount_d < VSyncEnd));
    enable_d      = hactive_d & vactive_d;
    col_d         = hactive_d ? hcount_d : 10'd0;
    row_d         = vactive_d ? vcount_d[8:0] : 9'd0;
    frame_start_d = (hcount_d == 10'd0) && (vcount_d == 10'd0);
  end

  // Reset parks the counters on the last pixel of a frame; the output reset values are the
  // decode of that pixel, so the first edge after release lands on (0,0) with no lost pixel.
  always_ff @(posedge clk25) begin
    if (reset) begin
      hcount_q    <= HLast;
      vcount_q    <= VLast;
      Hsync       <= 1'b1;
      Hactive     <= 1'b0;
      Vsync       <= 1'b1;
      Vactive     <= 1'b0;
      enable      <= 1'b0;
      Row         <= 9'd0;
      Col         <= 10'd0;
      frame_start <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      Hsync       <= hsync_d;
      Hactive     <= hactive_d;
      Vsync       <= vsync_d;
      Vactive     <= vactive_d;
      enable      <= enable_d;
      Row         <= row_d;
      Col         <= col_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_gerador_sincronismo.sv
// Bench for gerador_sincronismo: a full-size instance checks reset, the first lines and a
// mid-line reset; a reduced-timing instance (H 8/2/3/2, V 4/1/1/1) is run over a whole frame.
module tb_gerador_sincronismo;

  typedef struct packed {
    logic       hs;
    logic       ha;
    logic       vs;
    logic       va;
    logic       en;
    logic [8:0] row;
    logic [9:0] col;
    logic       fs;
  } obs_t;

  // t = cycles since the first (0,0) after reset release.
  typedef struct {
    int   t;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_f, rst_s;
  logic       f_hs, f_ha, f_vs, f_va, f_en, f_fs;
  logic [8:0] f_row;
  logic [9:0] f_col;
  logic       s_hs, s_ha, s_vs, s_va, s_en, s_fs;
  logic [8:0] s_row;
  logic [9:0] s_col;
  obs_t       obs_f, obs_s;

  assign obs_f = {f_hs, f_ha, f_vs, f_va, f_en, f_row, f_col, f_fs};
  assign obs_s = {s_hs, s_ha, s_vs, s_va, s_en, s_row, s_col, s_fs};

  gerador_sincronismo dut_full (
    .clk25       (clk),
    .reset       (rst_f),
    .Hsync       (f_hs),
    .Hactive     (f_ha),
    .Vsync       (f_vs),
    .Vactive     (f_va),
    .enable      (f_en),
    .Row         (f_row),
    .Col         (f_col),
    .frame_start (f_fs)
  );

  gerador_sincronismo #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1)
  ) dut_small (
    .clk25       (clk),
    .reset       (rst_s),
    .Hsync       (s_hs),
    .Hactive     (s_ha),
    .Vsync       (s_vs),
    .Vactive     (s_va),
    .enable      (s_en),
    .Row         (s_row),
    .Col         (s_col),
    .frame_start (s_fs)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic obs_t mk(input logic hs, input logic ha, input logic vs, input logic va,
                              input logic en, input int row, input int col, input logic fs);
    obs_t o;
    o.hs  = hs;
    o.ha  = ha;
    o.vs  = vs;
    o.va  = va;
    o.en  = en;
    o.row = 9'(row);
    o.col = 10'(col);
    o.fs  = fs;
    return o;
  endfunction

  task automatic check(input string name, input int t, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
    end
  endtask

  task automatic check_obs(input string name, input int t, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d actual hs%b ha%b vs%b va%b en%b row%0d col%0d fs%b required hs%b ha%b vs%b va%b en%b row%0d col%0d fs%b",
               name, t, act.hs, act.ha, act.vs, act.va, act.en, act.row, act.col, act.fs,
               exp.hs, exp.ha, exp.vs, exp.va, exp.en, exp.row, exp.col, exp.fs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vf[12];
  vec_t vs_tab[20];

  initial begin
    int   k;
    int   hs_low, ha_n, col_err, row_err, fs_extra;
    int   vs_low, vs_first, en_n, fs_n;
    obs_t rst_obs;

    rst_obs = mk(1, 0, 1, 0, 0, 0, 0, 0);

    //            t      hs ha vs va en row col fs
    vf[0]  = '{0,    mk(1, 1, 1, 1, 1, 0, 0,   1)};
    vf[1]  = '{1,    mk(1, 1, 1, 1, 1, 0, 1,   0)};
    vf[2]  = '{639,  mk(1, 1, 1, 1, 1, 0, 639, 0)};
    vf[3]  = '{640,  mk(1, 0, 1, 1, 0, 0, 0,   0)};
    vf[4]  = '{655,  mk(1, 0, 1, 1, 0, 0, 0,   0)};
    vf[5]  = '{656,  mk(0, 0, 1, 1, 0, 0, 0,   0)};
    vf[6]  = '{751,  mk(0, 0, 1, 1, 0, 0, 0,   0)};
    vf[7]  = '{752,  mk(1, 0, 1, 1, 0, 0, 0,   0)};
    vf[8]  = '{799,  mk(1, 0, 1, 1, 0, 0, 0,   0)};
    vf[9]  = '{800,  mk(1, 1, 1, 1, 1, 1, 0,   0)};
    vf[10] = '{1605, mk(1, 1, 1, 1, 1, 2, 5,   0)};
    vf[11] = '{2300, mk(0, 0, 1, 1, 0, 2, 0,   0)};

    // Reduced timing: line 15 clocks (act 0..7, fp 8..9, sync 10..12, bp 13..14),
    // frame 7 lines (act 0..3, fp 4, sync 5, bp 6).
    vs_tab[0]  = '{0,   mk(1, 1, 1, 1, 1, 0, 0, 1)};
    vs_tab[1]  = '{7,   mk(1, 1, 1, 1, 1, 0, 7, 0)};
    vs_tab[2]  = '{8,   mk(1, 0, 1, 1, 0, 0, 0, 0)};
    vs_tab[3]  = '{10,  mk(0, 0, 1, 1, 0, 0, 0, 0)};
    vs_tab[4]  = '{12,  mk(0, 0, 1, 1, 0, 0, 0, 0)};
    vs_tab[5]  = '{13,  mk(1, 0, 1, 1, 0, 0, 0, 0)};
    vs_tab[6]  = '{14,  mk(1, 0, 1, 1, 0, 0, 0, 0)};
    vs_tab[7]  = '{15,  mk(1, 1, 1, 1, 1, 1, 0, 0)};
    vs_tab[8]  = '{52,  mk(1, 1, 1, 1, 1, 3, 7, 0)};
    vs_tab[9]  = '{53,  mk(1, 0, 1, 1, 0, 3, 0, 0)};
    vs_tab[10] = '{59,  mk(1, 0, 1, 1, 0, 3, 0, 0)};
    vs_tab[11] = '{60,  mk(1, 1, 1, 0, 0, 0, 0, 0)};
    vs_tab[12] = '{61,  mk(1, 1, 1, 0, 0, 0, 1, 0)};
    vs_tab[13] = '{75,  mk(1, 1, 0, 0, 0, 0, 0, 0)};
    vs_tab[14] = '{86,  mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vs_tab[15] = '{89,  mk(1, 0, 0, 0, 0, 0, 0, 0)};
    vs_tab[16] = '{90,  mk(1, 1, 1, 0, 0, 0, 0, 0)};
    vs_tab[17] = '{104, mk(1, 0, 1, 0, 0, 0, 0, 0)};
    vs_tab[18] = '{105, mk(1, 1, 1, 1, 1, 0, 0, 1)};
    vs_tab[19] = '{106, mk(1, 1, 1, 1, 1, 0, 1, 0)};

    // ---- Full-size instance: reset held 3 cycles, then release.
    rst_f = 1'b1;
    rst_s = 1'b1;
    repeat (3) tick();
    check_obs("full_reset", -1, obs_f, rst_obs);
    check_obs("small_reset", -1, obs_s, rst_obs);
    rst_f = 1'b0;
    tick();

    k = 0; hs_low = 0; ha_n = 0; col_err = 0; row_err = 0; fs_extra = 0;
    for (int t = 0; t <= 2300; t++) begin
      int hc, vc;
      hc = t % 800;
      vc = t / 800;
      if (k < 12 && vf[k].t == t) begin
        check_obs("full_vec", t, obs_f, vf[k].exp);
        k++;
      end
      if (t < 800) begin
        if (!f_hs) hs_low++;
        if (f_ha) ha_n++;
      end
      if (int'(f_col) != ((hc < 640) ? hc : 0)) col_err++;
      if (int'(f_row) != vc) row_err++;
      if (t != 0 && f_fs) fs_extra++;
      if (t < 2300) tick();
    end
    check("full_table_reached", 2300, k, 12);
    check("full_hsync_low_per_line", 799, hs_low, 96);
    check("full_hactive_per_line", 799, ha_n, 640);
    check("full_col_track_errors", 2300, col_err, 0);
    check("full_row_track_errors", 2300, row_err, 0);
    check("full_extra_frame_start", 2300, fs_extra, 0);

    // One-cycle reset while Hsync is low (line 2, hcount 700).
    rst_f = 1'b1;
    tick();
    check_obs("full_midreset", 2301, obs_f, rst_obs);
    rst_f = 1'b0;
    tick();
    check_obs("full_after_reset_0", 0, obs_f, mk(1, 1, 1, 1, 1, 0, 0, 1));
    tick();
    check_obs("full_after_reset_1", 1, obs_f, mk(1, 1, 1, 1, 1, 0, 1, 0));

    // ---- Reduced-timing instance: one whole frame plus the next frame start.
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    tick();

    k = 0; hs_low = 0; vs_low = 0; vs_first = -1; en_n = 0; fs_n = 0;
    for (int t = 0; t <= 106; t++) begin
      if (k < 20 && vs_tab[k].t == t) begin
        check_obs("small_vec", t, obs_s, vs_tab[k].exp);
        k++;
      end
      if (t < 105) begin
        if (!s_hs) hs_low++;
        if (!s_vs) begin
          vs_low++;
          if (vs_first < 0) vs_first = t;
        end
        if (s_en) en_n++;
        if (s_fs) fs_n++;
      end
      if (t < 106) tick();
    end
    check("small_table_reached", 106, k, 20);
    check("small_hsync_low_per_frame", 104, hs_low, 21);
    check("small_vsync_low_per_frame", 104, vs_low, 15);
    check("small_vsync_first_low", 104, vs_first, 75);
    check("small_enable_per_frame", 104, en_n, 32);
    check("small_frame_start_per_frame", 104, fs_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gerador_sincronismo.md
# gerador_sincronismo

VGA 640x480@60 Hz timing generator, clocked by the 25 MHz pixel clock. It drives the `Hsync`/`Hactive`/`Vsync`/`Vactive`/`enable` strobes consumed by the image generator, which draws the circle and background. It also exports the current pixel coordinates and a frame-start pulse so the game/position logic can update `CircleRow`/`CircleCol` between frames.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `clk25`  in  1  pixel clock; one clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `Hsync`  out  1  horizontal sync, active-low
- `Hactive`  out  1  high during visible columns
- `Vsync`  out  1  vertical sync, active-low
- `Vactive`  out  1  high during visible lines
- `enable`  out  1  `Hactive & Vactive`
- `Row`  out  9  current visible line, 0..479; 0 outside `Vactive`
- `Col`  out  10  current visible column, 0..639; 0 outside `Hactive`
- `frame_start`  out  1  one-cycle pulse at pixel (0,0)

## Operation
- Totals: H_TOTAL = 800 and V_TOTAL = 525, each the sum of its four parameters.
- Internal counters: `hcount` 10 bits (0..H_TOTAL-1) and `vcount` 10 bits (0..V_TOTAL-1).
- `hcount` increments every clk25 and wraps from H_TOTAL-1 to 0.
- `vcount` increments only on the `hcount` wrap. It wraps from V_TOTAL-1 to 0 on the same edge as the `hcount` wrap.
- Horizontal regions, by `hcount` value:
  - ACTIVE: 0..639
  - FRONT: 640..655
  - SYNC: 656..751
  - BACK: 752..799
- Vertical regions, by `vcount` value:
  - ACTIVE: 0..479
  - FRONT: 480..489
  - SYNC: 490..491
  - BACK: 492..524
- Decode rules:
  - `Hactive` = (hcount < H_ACTIVE)
  - `Hsync` = 0 in the horizontal SYNC region, else 1
  - `Vactive` and `Vsync` follow the same rules using `vcount`
  - `enable` = `Hactive & Vactive`
- `Col` = hcount when `Hactive`, else 0. `Row` = vcount[8:0] when `Vactive`, else 0.
- `frame_start` = 1 only when hcount = 0 and vcount = 0.
- Every output is a register. Each register is loaded from the decode of the counters' next value, so the outputs during a cycle match the counter value held during that same cycle, with no combinational glitches.
- Vertical outputs change only on cycles where hcount = 0.
- All comparisons are unsigned, with no intermediate wider than 10 bits.

## Timing
- Reset (synchronous, `reset` = 1 at the rising edge):
  - counters load hcount = 799 and vcount = 524, the last pixel of a frame
  - outputs: `Hsync` = 1, `Vsync` = 1, `Hactive` = 0, `Vactive` = 0, `enable` = 0, `Row` = 0, `Col` = 0, `frame_start` = 0
- These reset values equal the decode of (799,524). Consequently the first edge with `reset` = 0 moves to (0,0) with `frame_start` = 1, `enable` = 1 and `Row` = `Col` = 0. No pixel of the first frame is lost.
- Reset asserted mid-frame: takes effect at the next edge and overrides counting that cycle. No partial sync pulse may extend past that edge.
- Latency: none beyond the counter. The outputs in cycle n describe pixel n.
- Line period is 800 clocks and frame period is 420000 clocks.
- `Hsync` low for exactly 96 clocks per line. `Vsync` low for exactly 1600 clocks (2 lines), starting at hcount = 0 of line 490.
- `frame_start` is high for exactly 1 clock per frame.
- `enable` is high for exactly 640 × 480 = 307200 clocks per frame.
- Simultaneous wraps (799,524) → (0,0): both counters wrap on the same edge and all vertical and horizontal outputs update together.

## Test plan
- Reset held 3 cycles, then released → the first post-release cycle shows (`Row`,`Col`) = (0,0), `frame_start` = 1, `enable` = 1, `Hsync` = `Vsync` = 1. The next cycle shows `Col` = 1 and `frame_start` = 0.
- Run one line from (0,0) → `Hactive` falls on the cycle after `Col` = 639. `Hsync` is low on counts 656..751 (96 cycles) and high elsewhere. `Col` returns to 0 exactly 800 cycles after the first (0,0).
- Run a full frame → `Vsync` is low for 1600 consecutive cycles beginning 490 × 800 = 392000 cycles after `frame_start`. Counted `enable` cycles = 307200. The next `frame_start` arrives 420000 cycles later.
- Check the last visible pixel: at `Row` = 479, `Col` = 639 then `enable` = 1; the next cycle has `enable` = 0 and `Col` = 0. `Vactive` stays 1 until the line wraps, then falls to 0 with `Row` = 0.
- Assert reset for 1 cycle at an arbitrary mid-frame point (e.g. vcount = 300, hcount = 700) → the following cycle has reset outputs. The cycle after reset falls shows (0,0) with `frame_start` = 1.
- Parameter sanity: instantiate with reduced timing (H: 8/2/3/2; V: 4/1/1/1) → H_TOTAL = 15 and V_TOTAL = 7. Sync widths are 3 clocks and 15 clocks, and the frame period is 105 clocks.
